// File: rtl/fifo_rd_stream_adapter.sv
// Read-side consumer of the async FIFO: pops the FIFO when credit allows, captures rData a cycle
// later into a 2-entry output buffer, and re-presents the words on a valid/ready stream.
module fifo_rd_stream_adapter #(
  parameter int DATA_SIZE = 12,
  parameter int COUNT_W   = 16
) (
  input  logic                 rclk,
  input  logic                 wrst,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 rEmpty,
  input  logic [DATA_SIZE-1:0] rData,
  output logic                 rinc,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic [COUNT_W-1:0]   rd_count,
  output logic [1:0]           state_dbg
);

  // Stream handshake: a word transfers on every rising rclk where m_valid && m_ready.
  // m_valid never drops and m_data never changes while a word is waiting for m_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] b0, b1;
  logic [1:0]           cnt;
  logic                 inflight;
  logic                 pop;
  logic                 push;
  logic                 flush_now;
  logic [2:0]           occ;

  assign m_valid   = (cnt != 2'd0);
  assign m_data    = b0;
  assign pop       = m_valid && m_ready;
  assign state_dbg = state_q;
  assign occ       = {1'b0, cnt} + {2'b00, inflight};

  // Words landing during or after a flush request are discarded.
  assign flush_now = (state_q == RUN) && flush;
  assign push      = inflight && (state_q == RUN) && !flush;

  always_ff @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rinc    = 1'b0;
    busy    = (cnt != 2'd0) || inflight;
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        // Credit check: buffered + in-flight words after this cycle's pop must leave room.
        rinc = en && !rEmpty && (occ < (3'd2 + {2'b00, pop}));
        if (flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (!inflight) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rinc;
    end
  end

  always_ff @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      cnt <= 2'd0;
      b0  <= '0;
      b1  <= '0;
    end else if (flush_now) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            b0 <= rData;
          end else begin
            b1 <= rData;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          b0  <= b1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Head leaves while the new word enters at the tail.
          if (cnt == 2'd1) begin
            b0 <= rData;
          end else begin
            b0 <= b1;
            b1 <= rData;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge rclk) disable iff (!wrst) occ <= 3'd2);

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: a behavioural FIFO model feeds the DUT and a
// monitor records every rinc and stream transfer for the per-scenario checks.
module tb_fifo_rd_stream_adapter;

  localparam int DW = 12;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          wrst = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          rEmpty;
  logic [DW-1:0] rData;
  logic          rinc;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] rd_count;
  logic [1:0]    state_dbg;

  logic [DW-1:0] mem [0:63];
  int            wptr = 0;
  int            rptr;
  int            cyc = 0;
  int            bad_rinc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] got_q[$];
  int            pop_cyc_q[$];
  int            rinc_cyc_q[$];
  logic [DW-1:0] exp_q[$];

  fifo_rd_stream_adapter #(.DATA_SIZE(DW), .COUNT_W(CW)) dut (
    .rclk(rclk), .wrst(wrst), .en(en), .flush(flush), .rEmpty(rEmpty), .rData(rData),
    .rinc(rinc), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .rd_count(rd_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / FIFO model / monitor ----------------
  always #5 rclk = ~rclk;

  assign rEmpty = (rptr == wptr);

  always @(posedge rclk or negedge wrst) begin
    if (!wrst) begin
      rptr  <= 0;
      rData <= '0;
    end else if (rinc && !rEmpty) begin
      rData <= mem[rptr[5:0]];
      rptr  <= rptr + 1;
    end
  end

  always @(posedge rclk) begin
    if (wrst) begin
      if (rinc) begin
        rinc_cyc_q.push_back(cyc);
        if (rEmpty || !en) bad_rinc++;
      end
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        pop_cyc_q.push_back(cyc);
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    wrst    = 1'b0;
    wptr    = 0;
    flush   = 1'b0;
    m_ready = 1'b0;
    en      = 1'b1;
    repeat (2) tick();
    wrst = 1'b1;
  endtask

  task automatic load_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wptr[5:0]] = DW'(first + i);
      wptr++;
    end
  endtask

  task automatic check_stream(input string name, input int base);
    n_checks++;
    if (got_q.size() - base !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d words, expected %0d", name, got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[base + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s word %0d: got %h, expected %h", name, i, got_q[base + i], exp_q[i]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    n_checks++;
    if ({rinc, m_valid, busy, m_data, rd_count, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rinc=%b vld=%b busy=%b data=%h cnt=%0d st=%0d, expected all 0",
               rinc, m_valid, busy, m_data, rd_count, state_dbg);
    end
    do_reset();
    tick();
    n_checks++;
    if (state_dbg !== 2'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_to_run: got st=%0d busy=%b, expected st=1 busy=0", state_dbg, busy);
    end
    load_words(16'h100, 8);
    m_ready = 1'b1;
    repeat (4) tick();
    m_ready = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b1 || rd_count === '0) begin
      n_fail++;
      $display("FAIL reset_midstream_setup: got busy=%b cnt=%0d, expected busy=1 cnt>0", busy, rd_count);
    end
    #2;
    wrst = 1'b0;
    wptr = 0;
    #1;
    n_checks++;
    if ({rinc, m_valid, busy, m_data, rd_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got rinc=%b vld=%b busy=%b data=%h cnt=%0d, expected all 0",
               rinc, m_valid, busy, m_data, rd_count);
    end
    tick();
    wrst    = 1'b1;
    m_ready = 1'b1;
    begin
      int base = got_q.size();
      repeat (6) tick();
      n_checks++;
      if (got_q.size() !== base || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_stale: got %0d words vld=%b, expected 0 words vld=0", got_q.size() - base, m_valid);
      end
    end
  endtask

  task automatic test_streaming();
    int gb, rb;
    do_reset();
    m_ready = 1'b1;
    load_words(1, 8);
    gb = got_q.size();
    rb = rinc_cyc_q.size();
    repeat (14) tick();
    n_checks++;
    if (rinc_cyc_q.size() - rb !== 8 || rinc_cyc_q[rb + 7] - rinc_cyc_q[rb] !== 7) begin
      n_fail++;
      $display("FAIL stream_rinc: got %0d pops, expected 8 consecutive", rinc_cyc_q.size() - rb);
    end
    exp_q.delete();
    for (int i = 1; i <= 8; i++) exp_q.push_back(DW'(i));
    check_stream("stream_data", gb);
    n_checks++;
    if (got_q.size() - gb >= 8 && pop_cyc_q[gb + 7] - pop_cyc_q[gb] !== 7) begin
      n_fail++;
      $display("FAIL stream_gapless: got span %0d, expected 7", pop_cyc_q[gb + 7] - pop_cyc_q[gb]);
    end
    n_checks++;
    if (rd_count !== 4'd8) begin
      n_fail++;
      $display("FAIL stream_count: got %0d, expected 8", rd_count);
    end
  endtask

  task automatic test_backpressure();
    int gb, rb;
    do_reset();
    load_words(1, 6);
    gb = got_q.size();
    rb = rinc_cyc_q.size();
    repeat (10) tick();
    n_checks++;
    if (rinc_cyc_q.size() - rb !== 2 || m_valid !== 1'b1 || m_data !== 12'h001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: got rincs=%0d vld=%b data=%h busy=%b, expected 2 1 001 1",
               rinc_cyc_q.size() - rb, m_valid, m_data, busy);
    end
    m_ready = 1'b1;
    repeat (10) tick();
    exp_q.delete();
    for (int i = 1; i <= 6; i++) exp_q.push_back(DW'(i));
    check_stream("bp_data", gb);
    n_checks++;
    if (got_q.size() - gb >= 6 && pop_cyc_q[gb + 5] - pop_cyc_q[gb] !== 5) begin
      n_fail++;
      $display("FAIL bp_gapless: got span %0d, expected 5", pop_cyc_q[gb + 5] - pop_cyc_q[gb]);
    end
  endtask

  task automatic test_flush();
    int gb;
    do_reset();
    load_words(1, 8);
    repeat (8) tick();
    gb = got_q.size();
    flush   = 1'b1;
    m_ready = 1'b1;
    tick();
    flush   = 1'b0;
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || state_dbg !== 2'd2 || busy !== 1'b1 || rd_count !== 4'd1) begin
      n_fail++;
      $display("FAIL flush_entry: got vld=%b st=%0d busy=%b cnt=%0d, expected 0 2 1 1",
               m_valid, state_dbg, busy, rd_count);
    end
    repeat (2) tick();
    n_checks++;
    if (state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL flush_return: got st=%0d, expected 1", state_dbg);
    end
    m_ready = 1'b1;
    repeat (12) tick();
    exp_q = '{12'h001, 12'h004, 12'h005, 12'h006, 12'h007, 12'h008};
    check_stream("flush_data", gb);
    n_checks++;
    if (rd_count !== 4'd6) begin
      n_fail++;
      $display("FAIL flush_count: got %0d, expected 6", rd_count);
    end
  endtask

  task automatic test_empty_edge();
    int rb;
    do_reset();
    m_ready = 1'b1;
    repeat (3) tick();
    rb = rinc_cyc_q.size();
    load_words(12'hABC, 1);
    #1;
    n_checks++;
    if (rinc !== 1'b1 || rb !== 0 && rinc_cyc_q.size() !== rb) begin
      n_fail++;
      $display("FAIL empty_rinc: got rinc=%b, expected 1", rinc);
    end
    tick();
    n_checks++;
    if (rinc !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_inflight: got rinc=%b vld=%b, expected 0 0", rinc, m_valid);
    end
    tick();
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 12'hABC) begin
      n_fail++;
      $display("FAIL empty_land: got vld=%b data=%h, expected 1 abc", m_valid, m_data);
    end
    repeat (4) tick();
    n_checks++;
    if (rinc_cyc_q.size() - rb !== 1 || m_valid !== 1'b0 || rd_count !== 4'd1) begin
      n_fail++;
      $display("FAIL empty_single: got rincs=%0d vld=%b cnt=%0d, expected 1 0 1",
               rinc_cyc_q.size() - rb, m_valid, rd_count);
    end
  endtask

  task automatic test_en_toggle_wrap();
    int gb, bad0, guard;
    do_reset();
    m_ready = 1'b1;
    load_words(12'h200, 18);
    gb    = got_q.size();
    bad0  = bad_rinc;
    guard = 0;
    while (got_q.size() - gb < 18 && guard < 300) begin
      if (guard % 3 == 0) en = ~en;
      tick();
      guard++;
    end
    en = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL en_timeout: got %0d words after %0d clks, expected 18", got_q.size() - gb, guard);
    end
    exp_q.delete();
    for (int i = 0; i < 18; i++) exp_q.push_back(DW'(12'h200 + i));
    check_stream("en_data", gb);
    n_checks++;
    if (rd_count !== 4'd2) begin
      n_fail++;
      $display("FAIL en_wrap: got %0d, expected 2", rd_count);
    end
    n_checks++;
    if (bad_rinc !== bad0) begin
      n_fail++;
      $display("FAIL en_illegal_rinc: got %0d, expected 0", bad_rinc - bad0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_empty_edge();
    test_en_toggle_wrap();
    n_checks++;
    if (bad_rinc !== 0) begin
      n_fail++;
      $display("FAIL rinc_when_empty_or_disabled: got %0d, expected 0", bad_rinc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
